contador_mod_param: RTL
=======================

Name: contador_mod_param

Overview:
- Parametrised successor to the free-running 5-bit counter. Configurable width, terminal value and prescaler.
- Adds enable, synchronous load, up/down counting, free-run or one-shot mode, a terminal-count pulse and a sticky done flag.
- Used as the Morse timing base: counts dot-unit steps for dot, dash and gap durations from the system clock.

Parameters:
- WIDTH, 5: counter width in bits.
- MAX_VAL, 31: upper terminal value; count range is 0..MAX_VAL. Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- PRESC, 1: enabled clock cycles per count step. Must be >= 1; 1 means step on every enabled cycle.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  count enable; gates the prescaler and the stepping.
- LOAD  in  1  synchronous load strobe.
- LOAD_VAL  in  WIDTH  value to load.
- DIR  in  1  0 = count up, 1 = count down.
- ONE_SHOT  in  1  0 = free-run (wrap), 1 = stop at terminal.
- salida  out  WIDTH  current count (registered).
- TC  out  1  terminal-count pulse, one cycle (registered).
- DONE  out  1  sticky "one-shot finished" flag (registered).

Behaviour:
- Reset: one clock; the reset is synchronous and active-high.
  - RST=1 at a rising edge sets salida=0, TC=0, DONE=0 and internal presc_cnt=0.
  - Reset has top priority, including mid-count and mid-prescale.
- Priority per edge: RST > LOAD > step > hold.
- Load:
  - LOAD=1 applies regardless of EN.
  - salida <= min(LOAD_VAL, MAX_VAL); LOAD_VAL > MAX_VAL clamps to MAX_VAL.
  - presc_cnt <= 0, TC <= 0, DONE <= 0.
- Prescaler (presc_cnt, width clog2(PRESC), at least 1 bit):
  - EN=0: presc_cnt and salida hold.
  - EN=1 and presc_cnt < PRESC-1: presc_cnt increments, no step.
  - EN=1 and presc_cnt == PRESC-1: presc_cnt <= 0 and a step occurs this edge.
  - First step occurs PRESC enabled cycles after reset or load.
- Step, DIR=0 (terminal = MAX_VAL):
  - salida < MAX_VAL: salida+1.
  - salida == MAX_VAL, free-run: salida <= 0, TC <= 1.
  - salida == MAX_VAL, one-shot: salida holds MAX_VAL, TC <= 1, DONE <= 1.
- Step, DIR=1 (terminal = 0):
  - salida > 0: salida-1.
  - salida == 0, free-run: salida <= MAX_VAL, TC <= 1.
  - salida == 0, one-shot: salida holds 0, TC <= 1, DONE <= 1.
- TC: high exactly one cycle after the terminal step edge; 0 on every other edge.
- DONE=1:
  - Steps are suppressed: salida frozen, no further TC, presc_cnt held at 0.
  - DONE clears only on RST, on LOAD, or on ONE_SHOT=0.
  - ONE_SHOT=0 while DONE=1: DONE clears on the next edge. Stepping resumes from the following enabled prescale period, in free-run mode, wrapping from the terminal.
- DIR or ONE_SHOT change mid-count: sampled at each step edge only; no effect on presc_cnt.
- Arithmetic: never leaves 0..MAX_VAL. Wrap is explicit to the parameter bound, not modulo 2**WIDTH.
- Parameter violations (MAX_VAL out of range, PRESC<1): elaboration-time error.

Test Plan:
- Reset: RST=1 for 2 cycles mid-count at salida=17, PRESC=1 -> salida=0, TC=0, DONE=0 on the first edge after RST.
- Free-run up, WIDTH=5, MAX_VAL=31, PRESC=1, EN=1 -> 0,1,…,31,0. TC=1 only in the cycle salida returns to 0. 64 cycles give exactly 2 TC pulses.
- Prescale with MAX_VAL=23, PRESC=3, EN=1 for 3 cycles, EN=0 for 5 cycles, then EN=1 -> salida steps every 3rd enabled cycle and holds while EN=0. After 72 enabled cycles from 0: salida=0 with exactly one TC.
- One-shot down: LOAD_VAL=2, DIR=1, ONE_SHOT=1, PRESC=1 -> 2,1,0 then held at 0. TC one pulse, DONE=1 stays set for 10 further cycles. Then ONE_SHOT=0 -> DONE clears next edge and salida wraps to MAX_VAL.
- Load: LOAD_VAL=31 with MAX_VAL=23 -> salida=23. LOAD=1 with EN=1 at presc_cnt=PRESC-1 -> load wins, no step, presc_cnt=0. LOAD=1 with EN=0 still loads.
- Simultaneous RST=1 and LOAD=1 with LOAD_VAL=9 -> salida=0, DONE=0.

Source files
------------

// File: rtl/contador_mod_param.sv
// Parameterised up/down counter with prescaler, synchronous load, free-run or
// one-shot mode, a one-cycle terminal-count pulse and a sticky done flag.
module contador_mod_param #(
    parameter int WIDTH   = 5,
    parameter int MAX_VAL = 31,
    parameter int PRESC   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             DIR,
    input  logic             ONE_SHOT,
    output logic [WIDTH-1:0] salida,
    output logic             TC,
    output logic             DONE
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_V     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V      = WIDTH'(1);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
    localparam logic [PW-1:0]    PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);

    if ((MAX_VAL < 1) || (longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 64'sd1))) begin : g_bad_max
        $error("contador_mod_param: MAX_VAL must lie in 1..2**WIDTH-1");
    end
    if (PRESC < 1) begin : g_bad_presc
        $error("contador_mod_param: PRESC must be >= 1");
    end

    logic [WIDTH-1:0] salida_r;
    logic [WIDTH-1:0] salida_nxt_s;
    logic [PW-1:0]    presc_cnt_r;
    logic [PW-1:0]    presc_nxt_s;
    logic             tc_r;
    logic             tc_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             at_term_s;

    // Next-state selection: LOAD beats stepping; a finished one-shot freezes
    // the count and keeps the prescaler parked at zero until released.
    always_comb begin
        salida_nxt_s = salida_r;
        presc_nxt_s  = presc_cnt_r;
        tc_nxt_s     = 1'b0;
        done_nxt_s   = done_r;
        at_term_s    = DIR ? (salida_r == ZERO_V) : (salida_r == MAX_V);

        if (LOAD) begin
            salida_nxt_s = (LOAD_VAL > MAX_V) ? MAX_V : LOAD_VAL;
            presc_nxt_s  = PRESC_ZERO;
            done_nxt_s   = 1'b0;
        end else if (done_r) begin
            presc_nxt_s = PRESC_ZERO;
            if (!ONE_SHOT) begin
                done_nxt_s = 1'b0;
            end else begin
                done_nxt_s = 1'b1;
            end
        end else if (EN) begin
            if (presc_cnt_r == PRESC_LAST) begin
                presc_nxt_s = PRESC_ZERO;
                if (at_term_s) begin
                    tc_nxt_s = 1'b1;
                    if (ONE_SHOT) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        salida_nxt_s = DIR ? MAX_V : ZERO_V;
                    end
                end else if (DIR) begin
                    salida_nxt_s = salida_r - ONE_V;
                end else begin
                    salida_nxt_s = salida_r + ONE_V;
                end
            end else begin
                presc_nxt_s = presc_cnt_r + PRESC_ONE;
            end
        end else begin
            presc_nxt_s  = presc_cnt_r;
            salida_nxt_s = salida_r;
        end
    end

    // State registers with synchronous reset taking top priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            salida_r    <= ZERO_V;
            presc_cnt_r <= PRESC_ZERO;
            tc_r        <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            salida_r    <= salida_nxt_s;
            presc_cnt_r <= presc_nxt_s;
            tc_r        <= tc_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign salida = salida_r;
    assign TC     = tc_r;
    assign DONE   = done_r;

endmodule
